// File: rtl/led_counter_ctrl.sv
// Command-driven 8-bit LED counter: tick prescaler, run/stop/hold sequencing,
// up/down stepping with preload and terminal-count detection.
module led_counter_ctrl #(
   parameter int unsigned CLK_FREQ = 10,
   parameter int unsigned DIV_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [DIV_W-1:0] cmd_data,
   output logic [7:0]       leds,
   output logic             running,
   output logic             done
);

   // state | meaning
   // IDLE  | prescaler frozen, leds held
   // RUN   | prescaler counts, one step per div cycles
   // HOLD  | one-shot run reached the limit; only START resumes
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;

   localparam logic [2:0] OP_NOP       = 3'd0;
   localparam logic [2:0] OP_START     = 3'd1;
   localparam logic [2:0] OP_STOP      = 3'd2;
   localparam logic [2:0] OP_CLEAR     = 3'd3;
   localparam logic [2:0] OP_LOAD      = 3'd4;
   localparam logic [2:0] OP_SET_DIV   = 3'd5;
   localparam logic [2:0] OP_SET_MODE  = 3'd6;
   localparam logic [2:0] OP_SET_LIMIT = 3'd7;

   localparam int unsigned DIV_HALF = CLK_FREQ / 2;
   localparam logic [DIV_W-1:0] DIV_RST = (DIV_HALF == 0) ? DIV_W'(1) : DIV_W'(DIV_HALF);

   state_t           state_q, state_d;
   logic [7:0]       leds_q, leds_d;
   logic [7:0]       limit_q, limit_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic             dir_q, dir_d;
   logic             oneshot_q, oneshot_d;
   logic             done_q, done_d;
   logic             running_q, running_d;
   logic             ready_q, ready_d;

   logic             accept;
   logic             step_due;
   logic             step_en;
   logic             cmd_preempts;
   logic [7:0]       step_val;

   always_comb begin
      accept       = cmd_valid && ready_q;
      step_due     = (state_q == ST_RUN) && (presc_q == div_q - DIV_W'(1));
      // Commands that reset the prescaler also swallow a coincident step.
      cmd_preempts = accept && (cmd_op >= OP_START) && (cmd_op <= OP_SET_DIV);
      step_en      = step_due && !cmd_preempts;
      step_val     = dir_q ? (leds_q - 8'd1) : (leds_q + 8'd1);

      state_d   = state_q;
      leds_d    = leds_q;
      limit_d   = limit_q;
      div_d     = div_q;
      presc_d   = presc_q;
      dir_d     = dir_q;
      oneshot_d = oneshot_q;
      done_d    = 1'b0;
      ready_d   = !accept;

      if (state_q == ST_RUN) begin
         presc_d = step_due ? '0 : presc_q + DIV_W'(1);
      end

      if (step_en) begin
         leds_d = step_val;
         if (step_val == limit_q) begin
            done_d = 1'b1;
            if (oneshot_q) state_d = ST_HOLD;
         end
      end

      if (accept) begin
         case (cmd_op)
            OP_START: begin
               presc_d = '0;
               state_d = ST_RUN;
            end
            OP_STOP: begin
               presc_d = '0;
               if (state_q != ST_HOLD) state_d = ST_IDLE;
            end
            OP_CLEAR: begin
               leds_d  = 8'd0;
               presc_d = '0;
            end
            OP_LOAD: begin
               leds_d  = cmd_data[7:0];
               presc_d = '0;
            end
            OP_SET_DIV: begin
               div_d   = (cmd_data == '0) ? DIV_W'(1) : cmd_data;
               presc_d = '0;
            end
            OP_SET_MODE: begin
               dir_d     = cmd_data[0];
               oneshot_d = cmd_data[1];
            end
            OP_SET_LIMIT: limit_d = cmd_data[7:0];
            default: ;
         endcase
      end

      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         leds_q    <= 8'd0;
         limit_q   <= 8'hFF;
         div_q     <= DIV_RST;
         presc_q   <= '0;
         dir_q     <= 1'b0;
         oneshot_q <= 1'b0;
         done_q    <= 1'b0;
         running_q <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         leds_q    <= leds_d;
         limit_q   <= limit_d;
         div_q     <= div_d;
         presc_q   <= presc_d;
         dir_q     <= dir_d;
         oneshot_q <= oneshot_d;
         done_q    <= done_d;
         running_q <= running_d;
         ready_q   <= ready_d;
      end
   end

   assign leds      = leds_q;
   assign running   = running_q;
   assign done      = done_q;
   assign cmd_ready = ready_q;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Directed bench for led_counter_ctrl: hand-computed leds/done/running values
// across run, wrap, one-shot hold, command/step collisions and reset.
module tb_led_counter_ctrl;

   localparam logic [2:0] OP_NOP       = 3'd0;
   localparam logic [2:0] OP_START     = 3'd1;
   localparam logic [2:0] OP_STOP      = 3'd2;
   localparam logic [2:0] OP_CLEAR     = 3'd3;
   localparam logic [2:0] OP_LOAD      = 3'd4;
   localparam logic [2:0] OP_SET_DIV   = 3'd5;
   localparam logic [2:0] OP_SET_MODE  = 3'd6;
   localparam logic [2:0] OP_SET_LIMIT = 3'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_data;
   logic [7:0]  leds;
   logic        running;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_cnt  = 0;
   int acc_cyc  = 0;
   int acc_prev = 0;

   led_counter_ctrl #(.CLK_FREQ(10), .DIV_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .leds      (leds),
      .running   (running),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [31:0] data);
      int w = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      while (!cmd_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      acc_prev  = acc_cyc;
      acc_cyc   = cyc_cnt;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0;
      cyc(2);
      chk("rst_leds",    32'(leds),      32'h00);
      chk("rst_running", 32'(running),   32'd0);
      chk("rst_done",    32'(done),      32'd0);
      chk("rst_ready",   32'(cmd_ready), 32'd1);
      rst = 1'b0;

      // Default divisor 5: first step 5 cycles after START
      send(OP_START, 0);
      chk("start_ready_low", 32'(cmd_ready), 32'd0);
      cyc(4);
      chk("start_c4_leds", 32'(leds),    32'h00);
      chk("start_running", 32'(running), 32'd1);
      cyc(1);
      chk("start_c5_leds", 32'(leds), 32'h01);
      cyc(5);
      chk("start_c10_leds", 32'(leds), 32'h02);

      // Wrap upward FE -> FF -> 00, FF hits default limit
      send(OP_LOAD, 32'hFE);
      send(OP_START, 0);
      cyc(4);
      chk("wrap_c4_leds", 32'(leds), 32'hFE);
      cyc(1);
      chk("wrap_ff_leds", 32'(leds), 32'hFF);
      chk("wrap_ff_done", 32'(done), 32'd1);
      cyc(1);
      chk("wrap_done_off", 32'(done), 32'd0);
      cyc(4);
      chk("wrap_00_leds", 32'(leds), 32'h00);

      // Down mode: 00 -> FF
      send(OP_SET_MODE, 32'd1);
      cyc(3);
      chk("down_pre_leds", 32'(leds), 32'h00);
      cyc(1);
      chk("down_ff_leds", 32'(leds), 32'hFF);
      chk("down_ff_done", 32'(done), 32'd1);

      send(OP_STOP, 0);
      chk("stop_running", 32'(running), 32'd0);
      cyc(10);
      chk("stop_frozen", 32'(leds), 32'hFF);

      // One-shot up to limit 3 at div 1
      send(OP_SET_DIV, 32'd0);
      send(OP_SET_LIMIT, 32'd3);
      send(OP_SET_MODE, 32'd2);
      send(OP_CLEAR, 0);
      chk("clear_leds", 32'(leds), 32'h00);
      send(OP_START, 0);
      cyc(1);
      chk("os_leds1", 32'(leds), 32'h01);
      chk("os_done1", 32'(done), 32'd0);
      cyc(1);
      chk("os_leds2", 32'(leds), 32'h02);
      cyc(1);
      chk("os_leds3",   32'(leds),    32'h03);
      chk("os_done3",   32'(done),    32'd1);
      chk("os_hold_run", 32'(running), 32'd0);
      cyc(1);
      chk("os_done_off", 32'(done), 32'd0);
      cyc(20);
      chk("os_hold_leds", 32'(leds), 32'h03);
      send(OP_START, 0);
      chk("os_restart_leds", 32'(leds),    32'h03);
      chk("os_restart_run",  32'(running), 32'd1);
      cyc(1);
      chk("os_restart_step", 32'(leds), 32'h04);
      // STOP coincident with a due step: no step
      send(OP_STOP, 0);
      chk("stop_vs_step", 32'(leds),    32'h04);
      chk("stop_vs_run",  32'(running), 32'd0);

      // LOAD coincident with a step at div 5
      send(OP_SET_MODE, 32'd0);
      send(OP_SET_DIV, 32'd5);
      send(OP_START, 0);
      cyc(4);
      chk("col_pre_leds", 32'(leds), 32'h04);
      send(OP_LOAD, 32'h40);
      chk("col_load_leds", 32'(leds), 32'h40);
      cyc(4);
      chk("col_c4_leds", 32'(leds), 32'h40);
      cyc(1);
      chk("col_step_leds", 32'(leds), 32'h41);

      // Back-to-back commands; LOAD onto limit must not pulse done
      send(OP_SET_LIMIT, 32'h10);
      chk("b2b_ready_low", 32'(cmd_ready), 32'd0);
      send(OP_LOAD, 32'h10);
      chk("b2b_spacing", 32'(acc_cyc - acc_prev), 32'd2);
      chk("load_lim_leds", 32'(leds), 32'h10);
      chk("load_lim_done", 32'(done), 32'd0);
      send(OP_LOAD, 32'h0F);
      cyc(4);
      chk("fr_pre_done", 32'(done), 32'd0);
      cyc(1);
      chk("fr_lim_leds", 32'(leds),    32'h10);
      chk("fr_lim_done", 32'(done),    32'd1);
      chk("fr_lim_run",  32'(running), 32'd1);
      cyc(1);
      chk("fr_done_off", 32'(done), 32'd0);
      cyc(4);
      chk("fr_cont_leds", 32'(leds), 32'h11);

      // Reset while a done-producing step is due
      send(OP_SET_LIMIT, 32'h12);
      cyc(3);
      rst = 1'b1;
      cyc(1);
      chk("mrst_leds",    32'(leds),      32'h00);
      chk("mrst_done",    32'(done),      32'd0);
      chk("mrst_running", 32'(running),   32'd0);
      chk("mrst_ready",   32'(cmd_ready), 32'd1);
      rst = 1'b0;
      send(OP_START, 0);
      cyc(4);
      chk("mrst_div_c4", 32'(leds), 32'h00);
      cyc(1);
      chk("mrst_div_c5", 32'(leds), 32'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
